// File: rtl/mm_ctrl_mailbox.sv
// CSR mailbox driving the AVMM bridge user port: one CMD word launches a single
// read or write, with busy/done status, address range check, sticky errors and ack timeout.
module mm_ctrl_mailbox #(
    parameter int CMD_W       = 16,
    parameter int USER_ADDR_W = 16,
    parameter int DATA_W      = 32,
    parameter int ADDR_MIN    = 0,
    parameter int ADDR_MAX    = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   i_usr_clk,
    input  logic                   i_usr_rst,
    input  logic                   i_csr_write,
    input  logic                   i_csr_read,
    input  logic                   i_csr_addr,
    input  logic [63:0]            i_csr_writedata,
    output logic [63:0]            o_csr_readdata,
    output logic [CMD_W-1:0]       o_usr_cmd,
    output logic [USER_ADDR_W-1:0] o_usr_addr,
    output logic [DATA_W-1:0]      o_usr_writedata,
    input  logic [DATA_W-1:0]      i_usr_readdata,
    input  logic                   i_usr_ack,
    output logic                   o_busy
);

    localparam int               TMR_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [32:0]      ADDR_LO   = 33'(ADDR_MIN);
    localparam logic [32:0]      ADDR_SPAN = 33'(ADDR_MAX - ADDR_MIN);
    localparam logic [1:0]       CMD_READ  = 2'd1;
    localparam logic [1:0]       CMD_WRITE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_CLEAR,
        S_DRAIN_HI,
        S_DRAIN_LO
    } state_t;

    state_t                 r_state;
    logic [63:0]            r_cmd_word;
    logic [CMD_W-1:0]       r_usr_cmd;
    logic [USER_ADDR_W-1:0] r_usr_addr;
    logic [DATA_W-1:0]      r_usr_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_err_busy;
    logic                   r_err_addr;
    logic [63:0]            r_csr_readdata;

    logic                   w_cmd_wr;
    logic                   w_sts_wr;
    logic [1:0]             w_req_cmd;
    logic [USER_ADDR_W-1:0] w_req_addr;
    logic                   w_req_valid;
    logic [32:0]            w_addr_off;
    logic                   w_addr_ok;
    logic                   w_busy;
    logic [31:0]            w_rdata_ext;
    logic [63:0]            w_status;

    assign w_cmd_wr    = i_csr_write && !i_csr_addr;
    assign w_sts_wr    = i_csr_write && i_csr_addr;
    assign w_req_cmd   = i_csr_writedata[1:0];
    assign w_req_addr  = i_csr_writedata[16 +: USER_ADDR_W];
    assign w_req_valid = (w_req_cmd == CMD_READ) || (w_req_cmd == CMD_WRITE);

    // Offset from ADDR_MIN wraps to a huge value below the window, so one compare covers both ends.
    assign w_addr_off  = 33'(w_req_addr) - ADDR_LO;
    assign w_addr_ok   = (w_addr_off <= ADDR_SPAN);

    assign w_busy      = (r_state != S_IDLE);

    always_comb begin
        w_rdata_ext               = '0;
        w_rdata_ext[DATA_W-1:0]   = r_rdata;
    end

    assign w_status = {w_rdata_ext, 27'd0, r_err_addr, r_err_busy, r_timeout, r_done, w_busy};

    always_ff @(posedge i_usr_clk) begin
        if (i_usr_rst) begin
            r_state        <= S_IDLE;
            r_cmd_word     <= '0;
            r_usr_cmd      <= '0;
            r_usr_addr     <= '0;
            r_usr_wdata    <= '0;
            r_rdata        <= '0;
            r_timer        <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_err_busy     <= 1'b0;
            r_err_addr     <= 1'b0;
            r_csr_readdata <= '0;
        end else begin
            if (i_csr_read) begin
                r_csr_readdata <= i_csr_addr ? w_status : r_cmd_word;
            end

            // W1C comes first so that any hardware set later in this block wins.
            if (w_sts_wr) begin
                if (i_csr_writedata[2]) r_timeout  <= 1'b0;
                if (i_csr_writedata[3]) r_err_busy <= 1'b0;
                if (i_csr_writedata[4]) r_err_addr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_wr && w_req_valid) begin
                        if (w_addr_ok) begin
                            r_cmd_word <= i_csr_writedata;
                            r_done     <= 1'b0;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_err_addr <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    r_usr_cmd   <= CMD_W'(r_cmd_word[1:0]);
                    r_usr_addr  <= r_cmd_word[16 +: USER_ADDR_W];
                    r_usr_wdata <= r_cmd_word[32 +: DATA_W];
                    r_timer     <= '0;
                    r_state     <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (i_usr_ack) begin
                        if (r_cmd_word[1:0] == CMD_READ) begin
                            r_rdata <= i_usr_readdata;
                        end
                        r_usr_cmd <= '0;
                        r_state   <= S_CLEAR;
                    end else if (r_timer == TMR_LAST) begin
                        r_timeout <= 1'b1;
                        r_usr_cmd <= '0;
                        r_state   <= S_DRAIN_HI;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TMR_ONE;
                    end
                end

                S_CLEAR: begin
                    if (!i_usr_ack) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                // The bridge may still complete the abandoned op; wait out its ack pulse.
                S_DRAIN_HI: begin
                    if (i_usr_ack) begin
                        r_state <= S_DRAIN_LO;
                    end
                end

                S_DRAIN_LO: begin
                    if (!i_usr_ack) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_usr_cmd <= '0;
                    r_state   <= S_IDLE;
                end
            endcase

            if (w_cmd_wr && (r_state != S_IDLE)) begin
                r_err_busy <= 1'b1;
            end
        end
    end

    assign o_csr_readdata  = r_csr_readdata;
    assign o_usr_cmd       = r_usr_cmd;
    assign o_usr_addr      = r_usr_addr;
    assign o_usr_writedata = r_usr_wdata;
    assign o_busy          = w_busy;

endmodule

// File: tb/tb_mm_ctrl_mailbox.sv
// Scoreboard bench for mm_ctrl_mailbox: stimulus queues expectations, a negedge monitor
// compares CSR read responses and tagged user-port probes.
module tb_mm_ctrl_mailbox;

    localparam int K_CMD   = 0;
    localparam int K_ADDR  = 1;
    localparam int K_WDATA = 2;
    localparam int K_BUSY  = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
        int          cyc;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        csr_write;
    logic        csr_read;
    logic        csr_addr;
    logic [63:0] csr_wdata;
    logic [31:0] usr_rdata;
    logic        ack;
    logic        sel;

    logic        wr_a, rd_a, ack_a, wr_b, rd_b, ack_b;
    logic [63:0] rdata_a, rdata_b;
    logic [15:0] cmd_a, cmd_b, addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        busy_a, busy_b;

    assign wr_a  = csr_write & ~sel;
    assign rd_a  = csr_read & ~sel;
    assign ack_a = ack & ~sel;
    assign wr_b  = csr_write & sel;
    assign rd_b  = csr_read & sel;
    assign ack_b = ack & sel;

    mm_ctrl_mailbox dut (
        .i_usr_clk       (clk),
        .i_usr_rst       (rst),
        .i_csr_write     (wr_a),
        .i_csr_read      (rd_a),
        .i_csr_addr      (csr_addr),
        .i_csr_writedata (csr_wdata),
        .o_csr_readdata  (rdata_a),
        .o_usr_cmd       (cmd_a),
        .o_usr_addr      (addr_a),
        .o_usr_writedata (wdata_a),
        .i_usr_readdata  (usr_rdata),
        .i_usr_ack       (ack_a),
        .o_busy          (busy_a)
    );

    mm_ctrl_mailbox #(.TIMEOUT_CYC(16)) dut_to (
        .i_usr_clk       (clk),
        .i_usr_rst       (rst),
        .i_csr_write     (wr_b),
        .i_csr_read      (rd_b),
        .i_csr_addr      (csr_addr),
        .i_csr_writedata (csr_wdata),
        .o_csr_readdata  (rdata_b),
        .o_usr_cmd       (cmd_b),
        .o_usr_addr      (addr_b),
        .o_usr_writedata (wdata_b),
        .i_usr_readdata  (usr_rdata),
        .i_usr_ack       (ack_b),
        .o_busy          (busy_b)
    );

    logic [63:0] m_rd;
    logic [15:0] m_cmd, m_addr;
    logic [31:0] m_wdata;
    logic        m_busy;
    assign m_rd    = sel ? rdata_b : rdata_a;
    assign m_cmd   = sel ? cmd_b   : cmd_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_wdata = sel ? wdata_b : wdata_a;
    assign m_busy  = sel ? busy_b  : busy_a;

    int   cyc = 0;
    logic rd_d = 1'b0;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_d <= csr_read;
    end

    chk_t rq[$];
    chk_t pq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            K_CMD:   return 64'(m_cmd);
            K_ADDR:  return 64'(m_addr);
            K_WDATA: return 64'(m_wdata);
            default: return 64'(m_busy);
        endcase
    endfunction

    // Monitor: read responses arrive the cycle after the strobe; probes are tagged with their cycle.
    initial begin
        chk_t e;
        forever begin
            @(negedge clk);
            if (rd_d) begin
                if (rq.size() == 0) begin
                    compare("unexpected_read", m_rd, 64'hFFFF_FFFF_FFFF_FFFF ^ m_rd);
                end else begin
                    e = rq.pop_front();
                    compare(e.name, m_rd, e.exp);
                end
            end
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                e = pq.pop_front();
                compare(e.name, actual(e.kind), e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic probe(input int kind, input logic [63:0] exp, input string name);
        chk_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        e.cyc  = cyc;
        pq.push_back(e);
    endtask

    task automatic csr_wr(input logic a, input logic [63:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic a, input logic [63:0] exp, input string name);
        chk_t e;
        e.name = name;
        e.kind = -1;
        e.exp  = exp;
        e.cyc  = cyc;
        rq.push_back(e);
        csr_addr = a;
        csr_read = 1'b1;
        tick();
        csr_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csr_write = 1'b0; csr_read = 1'b0; csr_addr = 1'b0;
        csr_wdata = '0; usr_rdata = '0; ack = 1'b0; sel = 1'b0;
        ticks(3);
        rst = 1'b0;

        // Reset state and a basic WRITE with a slow ack
        probe(K_CMD, 0, "rst_cmd");
        probe(K_BUSY, 0, "rst_busy");
        probe(K_ADDR, 0, "rst_addr");
        csr_rd(1'b1, 64'h0, "rst_status");
        csr_rd(1'b0, 64'h0, "rst_cmdword");
        csr_wr(1'b0, 64'hA5A5_0001_0010_0002);
        probe(K_CMD, 0, "t1_issue_cmd");
        probe(K_BUSY, 1, "t1_issue_busy");
        tick();
        probe(K_CMD, 2, "t1_cmd");
        probe(K_ADDR, 64'h10, "t1_addr");
        probe(K_WDATA, 64'hA5A5_0001, "t1_wdata");
        ticks(18);
        usr_rdata = 32'h1234_5678; ack = 1'b1;
        tick();
        probe(K_CMD, 0, "t1_cmd_noop");
        probe(K_BUSY, 1, "t1_clear_busy");
        usr_rdata = '0; ack = 1'b0;
        tick();
        probe(K_BUSY, 0, "t1_idle_busy");
        csr_rd(1'b1, 64'h2, "t1_status");
        csr_rd(1'b0, 64'hA5A5_0001_0010_0002, "t1_cmdword");

        // READ with captured data
        csr_wr(1'b0, 64'h0000_0000_0040_0001);
        tick();
        probe(K_CMD, 1, "t2_cmd");
        probe(K_ADDR, 64'h40, "t2_addr");
        csr_rd(1'b1, 64'h1, "t2_status_busy");
        ticks(2);
        usr_rdata = 32'hDEAD_BEEF; ack = 1'b1;
        tick();
        probe(K_CMD, 0, "t2_cmd_noop");
        usr_rdata = '0; ack = 1'b0;
        tick();
        csr_rd(1'b1, 64'hDEAD_BEEF_0000_0002, "t2_status_done");

        // Address range, W1C, ignored command code, top-of-range accept
        csr_wr(1'b0, 64'h0000_0000_0401_0001);
        probe(K_CMD, 0, "t3_oor_cmd");
        probe(K_BUSY, 0, "t3_oor_busy");
        tick();
        probe(K_CMD, 0, "t3_oor_cmd2");
        csr_rd(1'b1, 64'hDEAD_BEEF_0000_0012, "t3_err_addr");
        csr_rd(1'b0, 64'h0000_0000_0040_0001, "t3_cmdword_kept");
        csr_wr(1'b1, 64'h10);
        csr_rd(1'b1, 64'hDEAD_BEEF_0000_0002, "t3_w1c_err_addr");
        csr_wr(1'b0, 64'h0000_0000_0010_0003);
        probe(K_BUSY, 0, "t3_cmd3_busy");
        tick();
        probe(K_CMD, 0, "t3_cmd3_cmd");
        csr_rd(1'b1, 64'hDEAD_BEEF_0000_0002, "t3_cmd3_noflag");
        csr_wr(1'b0, 64'h0000_0000_0400_0001);
        tick();
        probe(K_CMD, 1, "t3_max_cmd");
        probe(K_ADDR, 64'h400, "t3_max_addr");
        usr_rdata = 32'h0BAD_F00D; ack = 1'b1;
        tick();
        usr_rdata = '0; ack = 1'b0;
        tick();
        csr_rd(1'b1, 64'h0BAD_F00D_0000_0002, "t3_max_status");

        // CMD write while busy
        csr_wr(1'b0, 64'h1111_2222_0020_0002);
        tick();
        probe(K_CMD, 2, "t4_cmd");
        probe(K_ADDR, 64'h20, "t4_addr");
        csr_wr(1'b0, 64'h3333_4444_0030_0001);
        probe(K_ADDR, 64'h20, "t4_addr_kept");
        probe(K_WDATA, 64'h1111_2222, "t4_wdata_kept");
        probe(K_CMD, 2, "t4_cmd_kept");
        csr_rd(1'b1, 64'h0BAD_F00D_0000_0009, "t4_err_busy");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        csr_rd(1'b1, 64'h0BAD_F00D_0000_000A, "t4_done");
        csr_rd(1'b0, 64'h1111_2222_0020_0002, "t4_cmdword");
        csr_wr(1'b1, 64'h8);
        csr_rd(1'b1, 64'h0BAD_F00D_0000_0002, "t4_w1c_err_busy");

        // Timeout on the TIMEOUT_CYC=16 instance
        tick();
        sel = 1'b1;
        csr_wr(1'b0, 64'h0000_0000_0005_0001);
        tick();
        probe(K_CMD, 1, "t5_cmd");
        ticks(15);
        probe(K_CMD, 1, "t5_last_wait_cmd");
        tick();
        probe(K_CMD, 0, "t5_timeout_cmd");
        probe(K_BUSY, 1, "t5_drain_busy");
        csr_rd(1'b1, 64'h5, "t5_timeout_status");
        usr_rdata = 32'hCAFE_0000; ack = 1'b1;
        tick();
        probe(K_BUSY, 1, "t5_late_ack_busy");
        tick();
        usr_rdata = '0; ack = 1'b0;
        probe(K_BUSY, 1, "t5_ack_drop_busy");
        tick();
        probe(K_BUSY, 0, "t5_idle_busy");
        csr_rd(1'b1, 64'h4, "t5_drained_status");
        begin
            chk_t e;
            e.name = "t5_rw_same_clk";
            e.kind = -1;
            e.exp  = 64'h4;
            e.cyc  = cyc;
            rq.push_back(e);
        end
        csr_addr = 1'b1; csr_wdata = 64'h4; csr_read = 1'b1; csr_write = 1'b1;
        tick();
        csr_read = 1'b0; csr_write = 1'b0;
        csr_rd(1'b1, 64'h0, "t5_w1c_timeout");
        tick();
        sel = 1'b0;

        // Reset mid-transaction, then a fresh command
        csr_wr(1'b0, 64'h0000_0000_0050_0001);
        tick();
        probe(K_CMD, 1, "t6_cmd");
        ticks(3);
        rst = 1'b1;
        tick();
        probe(K_CMD, 0, "t6_rst_cmd");
        probe(K_BUSY, 0, "t6_rst_busy");
        probe(K_ADDR, 0, "t6_rst_addr");
        rst = 1'b0;
        csr_rd(1'b1, 64'h0, "t6_rst_status");
        csr_rd(1'b0, 64'h0, "t6_rst_cmdword");
        csr_wr(1'b0, 64'h0000_600D_0060_0002);
        tick();
        probe(K_CMD, 2, "t6_new_cmd");
        probe(K_ADDR, 64'h60, "t6_new_addr");
        probe(K_WDATA, 64'h600D, "t6_new_wdata");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        csr_rd(1'b1, 64'h2, "t6_new_done");

        ticks(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
